// File: rtl/tpu_package.sv
// Shared TPU datapath constants and the weight-load FSM state type.
package tpu_package;

    localparam int MUL_SIZE      = 32;   // systolic array dimension, rows per weight tile
    localparam int DATA_W        = 8;    // weight element width
    localparam int WEIGHT_ADDR_W = 12;   // weight memory row address width

    typedef enum logic [1:0] {
        WL_IDLE  = 2'd0,
        WL_FETCH = 2'd1,
        WL_HOLD  = 2'd2
    } weight_load_state_t;

endpackage

// File: rtl/weight_load_control_unit_addr_gen.sv
// weight_tile_addr_gen: row/tile counters for the weight fetch and the
// resulting memory row address (base + tile*MUL_SIZE + row).
// `next` is the address of the row that the next read strobe fetches.
module weight_tile_addr_gen
    import tpu_package::*;
#(
    parameter int MUL_SIZE = tpu_package::MUL_SIZE,
    parameter int ADDR_W   = tpu_package::WEIGHT_ADDR_W,
    parameter int TILE_W   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        init,       // restart at row 0 of tile 0, capture base
    input  logic                        step,       // one row was read this cycle
    input  logic [ADDR_W-1:0]           base_addr,
    output logic [$clog2(MUL_SIZE)-1:0] row,
    output logic                        bank,       // tile parity selects the target bank
    output logic                        last_row,
    output logic [ADDR_W-1:0]           next
);

    localparam int ROW_W = $clog2(MUL_SIZE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

    logic [ADDR_W-1:0] base_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [TILE_W-1:0] tile_reg;
    logic [ADDR_W-1:0] offset;

    // MUL_SIZE is a power of two, so tile*MUL_SIZE + row is a plain concatenation.
    assign offset   = ADDR_W'({tile_reg, row_reg});
    assign next     = base_reg + offset;
    assign row      = row_reg;
    assign bank     = tile_reg[0];
    assign last_row = (row_reg == LAST_ROW);

    // Row counter wraps at the end of a tile and bumps the tile index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_reg <= '0;
            row_reg  <= '0;
            tile_reg <= '0;
        end else if (init) begin
            base_reg <= base_addr;
            row_reg  <= '0;
            tile_reg <= '0;
        end else if (step) begin
            if (last_row) begin
                row_reg  <= '0;
                tile_reg <= tile_reg + 1'b1;
            end else begin
                row_reg  <= row_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_load_control_unit.sv
// weight_load_control_unit: fills the idle bank of the systolic array's
// double-buffered weight registers from weight memory, one row per cycle,
// and tracks how many full banks wait for the compute controller.
// Optional build macro: WEIGHT_LOAD_PERF_EN adds starve_cycles_o, a saturating
// count of active cycles spent with no full bank available.
module weight_load_control_unit
#(
    parameter int MUL_SIZE = tpu_package::MUL_SIZE,
    parameter int DATA_W   = tpu_package::DATA_W,
    parameter int ADDR_W   = tpu_package::WEIGHT_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [7:0]                   U_dim_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic                         next_weight_tile_i,
    output logic                         weight_rd_en_o,
    output logic [ADDR_W-1:0]            weight_rd_addr_o,
    input  logic [MUL_SIZE*DATA_W-1:0]   weight_rd_data_i,
    output logic                         weight_wr_en_o,
    output logic                         weight_wr_bank_o,
    output logic [$clog2(MUL_SIZE)-1:0]  weight_wr_row_o,
    output logic [MUL_SIZE*DATA_W-1:0]   weight_wr_data_o,
    output logic                         compute_weights_rdy_o,
    output logic                         done_o
`ifdef WEIGHT_LOAD_PERF_EN
    ,
    output logic [31:0]                  starve_cycles_o
`endif
);

    import tpu_package::*;

    localparam int ROW_W = $clog2(MUL_SIZE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

    weight_load_state_t state_reg;

    logic             rd_en_reg;
    logic             wr_en_reg;
    logic [ROW_W-1:0] wr_row_reg;
    logic             wr_bank_reg;
    logic [1:0]       full_cnt_reg;
    logic [1:0]       full_cnt_next;
    logic [7:0]       tiles_left_reg;
    logic [7:0]       tiles_left_next;
    logic [7:0]       consumed_left_reg;
    logic             rdy_reg;
    logic             done_reg;

    logic [7:0]       start_tiles;
    logic             accept_start;
    logic             completion;
    logic             consume;
    logic             issue_last;

    logic [ROW_W-1:0] rd_row;
    logic             rd_bank;
    logic             rd_last_row;
    logic [ADDR_W-1:0] rd_addr;

    assign start_tiles  = U_dim_i >> ROW_W;
    assign accept_start = (state_reg == WL_IDLE) && start_i && (start_tiles != 8'd0);
    // A bank becomes full on the write of its last row.
    assign completion   = wr_en_reg && (wr_row_reg == LAST_ROW);
    // Consume pulses only count while a full bank exists.
    assign consume      = next_weight_tile_i && (full_cnt_reg != 2'd0);
    assign issue_last   = rd_en_reg && rd_last_row;

    weight_tile_addr_gen #(
        .MUL_SIZE (MUL_SIZE),
        .ADDR_W   (ADDR_W),
        .TILE_W   (8)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .init      (accept_start),
        .step      (rd_en_reg),
        .base_addr (base_addr_i),
        .row       (rd_row),
        .bank      (rd_bank),
        .last_row  (rd_last_row),
        .next      (rd_addr)
    );

    // Full-bank count after this edge: fill and consume on one edge cancel out.
    always_comb begin
        full_cnt_next = full_cnt_reg;
        if (completion && !consume) begin
            full_cnt_next = full_cnt_reg + 2'd1;
        end else if (!completion && consume) begin
            full_cnt_next = full_cnt_reg - 2'd1;
        end
        tiles_left_next = issue_last ? (tiles_left_reg - 8'd1) : tiles_left_reg;
    end

    // Fetch sequencing, write-stage pipeline, bank accounting and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg         <= WL_IDLE;
            rd_en_reg         <= 1'b0;
            wr_en_reg         <= 1'b0;
            wr_row_reg        <= '0;
            wr_bank_reg       <= 1'b0;
            full_cnt_reg      <= 2'd0;
            tiles_left_reg    <= 8'd0;
            consumed_left_reg <= 8'd0;
            rdy_reg           <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            wr_en_reg    <= rd_en_reg;
            wr_row_reg   <= rd_row;
            wr_bank_reg  <= rd_bank;
            full_cnt_reg <= full_cnt_next;
            rdy_reg      <= (full_cnt_next != 2'd0);
            if (consume) begin
                consumed_left_reg <= consumed_left_reg - 8'd1;
            end

            case (state_reg)
                WL_IDLE: begin
                    if (start_i) begin
                        if (start_tiles == 8'd0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg         <= WL_FETCH;
                            rd_en_reg         <= 1'b1;
                            tiles_left_reg    <= start_tiles;
                            consumed_left_reg <= start_tiles;
                            full_cnt_reg      <= 2'd0;
                            rdy_reg           <= 1'b0;
                        end
                    end
                end
                WL_FETCH: begin
                    if (issue_last) begin
                        tiles_left_reg <= tiles_left_next;
                        // Keep streaming only if the tile just issued still leaves a free bank.
                        if (!(full_cnt_next == 2'd0 && tiles_left_next != 8'd0)) begin
                            state_reg <= WL_HOLD;
                            rd_en_reg <= 1'b0;
                        end
                    end
                end
                WL_HOLD: begin
                    if (full_cnt_next < 2'd2 && tiles_left_reg != 8'd0) begin
                        state_reg <= WL_FETCH;
                        rd_en_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= WL_IDLE;
                    rd_en_reg <= 1'b0;
                end
            endcase

            // The final consume ends the pass regardless of the state branch above.
            if (consume && consumed_left_reg == 8'd1) begin
                done_reg  <= 1'b1;
                state_reg <= WL_IDLE;
                rd_en_reg <= 1'b0;
            end
        end
    end

    assign weight_rd_en_o        = rd_en_reg;
    assign weight_rd_addr_o      = rd_addr;
    assign weight_wr_en_o        = wr_en_reg;
    assign weight_wr_row_o       = wr_row_reg;
    assign weight_wr_bank_o      = wr_bank_reg;
    assign weight_wr_data_o      = weight_rd_data_i;
    assign compute_weights_rdy_o = rdy_reg;
    assign done_o                = done_reg;

`ifdef WEIGHT_LOAD_PERF_EN
    logic [31:0] starve_cnt_reg;

    // Saturating count of active cycles with no full bank for the array.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_reg <= 32'd0;
        end else if (state_reg == WL_IDLE && start_i) begin
            starve_cnt_reg <= 32'd0;
        end else if (state_reg != WL_IDLE && !rdy_reg && starve_cnt_reg != 32'hFFFF_FFFF) begin
            starve_cnt_reg <= starve_cnt_reg + 32'd1;
        end
    end

    assign starve_cycles_o = starve_cnt_reg;
`endif

endmodule

// File: tb/tb_weight_load_control_unit.sv
// Directed bench for weight_load_control_unit. Cycle 0 is the cycle in which
// start_i is high; outputs are sampled at the falling edge of each cycle.
module tb_weight_load_control_unit;
    import tpu_package::*;

    localparam int MS = 32;
    localparam int DW = 8;
    localparam int AW = 12;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic [7:0]      U_dim_i;
    logic [AW-1:0]   base_addr_i;
    logic            next_weight_tile_i;
    logic            weight_rd_en_o;
    logic [AW-1:0]   weight_rd_addr_o;
    logic [MS*DW-1:0] weight_rd_data_i;
    logic            weight_wr_en_o;
    logic            weight_wr_bank_o;
    logic [4:0]      weight_wr_row_o;
    logic [MS*DW-1:0] weight_wr_data_o;
    logic            compute_weights_rdy_o;
    logic            done_o;
`ifdef WEIGHT_LOAD_PERF_EN
    logic [31:0]     starve_cycles_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    weight_load_control_unit #(.MUL_SIZE(MS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .U_dim_i               (U_dim_i),
        .base_addr_i           (base_addr_i),
        .next_weight_tile_i    (next_weight_tile_i),
        .weight_rd_en_o        (weight_rd_en_o),
        .weight_rd_addr_o      (weight_rd_addr_o),
        .weight_rd_data_i      (weight_rd_data_i),
        .weight_wr_en_o        (weight_wr_en_o),
        .weight_wr_bank_o      (weight_wr_bank_o),
        .weight_wr_row_o       (weight_wr_row_o),
        .weight_wr_data_o      (weight_wr_data_o),
        .compute_weights_rdy_o (compute_weights_rdy_o),
        .done_o                (done_o)
`ifdef WEIGHT_LOAD_PERF_EN
        ,
        .starve_cycles_o       (starve_cycles_o)
`endif
    );

    task automatic start_pass(input logic [7:0] u, input logic [AW-1:0] base);
        start_i = 1'b1; U_dim_i = u; base_addr_i = base;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic consume_pulse();
        next_weight_tile_i = 1'b1;
        @(negedge clk_i);
        next_weight_tile_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({weight_rd_en_o, weight_rd_addr_o, weight_wr_en_o, weight_wr_bank_o, weight_wr_row_o,
             compute_weights_rdy_o, done_o} !== '0) begin
            errors++; $display("FAIL reset_outputs rd_en=%b addr=%h wr_en=%b bank=%b row=%0d rdy=%b done=%b required all 0",
                weight_rd_en_o, weight_rd_addr_o, weight_wr_en_o, weight_wr_bank_o, weight_wr_row_o,
                compute_weights_rdy_o, done_o);
        end
        checks++;
        if (dut.state_reg !== WL_IDLE || dut.full_cnt_reg !== 2'd0) begin
            errors++; $display("FAIL reset_state state=%0d full_cnt=%0d required 0/0", dut.state_reg, dut.full_cnt_reg);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        $display("test_reset done");
    endtask

    task automatic test_data_path();
        for (int i = 0; i < 2; i++) begin
            weight_rd_data_i = {8{$urandom()}};
            #1;
            checks++;
            if (weight_wr_data_o !== weight_rd_data_i) begin
                errors++; $display("FAIL wr_data_passthru got=%h required=%h", weight_wr_data_o, weight_rd_data_i);
            end
        end
        @(negedge clk_i);
        $display("test_data_path done");
    endtask

    // U=64 from 0x100: two back-to-back tiles, banks 0 then 1, rdy at cycle 34.
    task automatic test_single_pass();
        logic [AW-1:0] ea;
        logic [4:0] er;
        logic eb;
        start_pass(8'd64, 12'h100);
        for (int c = 1; c <= 66; c++) begin
            checks++;
            if (weight_rd_en_o !== (c <= 64)) begin
                errors++; $display("FAIL pass_rd_en cycle=%0d got=%b required=%b", c, weight_rd_en_o, (c <= 64));
            end
            if (c <= 64) begin
                ea = 12'h100 + AW'(c - 1);
                checks++;
                if (weight_rd_addr_o !== ea) begin
                    errors++; $display("FAIL pass_rd_addr cycle=%0d got=%h required=%h", c, weight_rd_addr_o, ea);
                end
            end
            checks++;
            if (weight_wr_en_o !== (c >= 2 && c <= 65)) begin
                errors++; $display("FAIL pass_wr_en cycle=%0d got=%b required=%b", c, weight_wr_en_o, (c >= 2 && c <= 65));
            end
            if (c >= 2 && c <= 65) begin
                er = 5'((c - 2) % MS);
                eb = ((c - 2) / MS) == 1;
                checks++;
                if (weight_wr_row_o !== er || weight_wr_bank_o !== eb) begin
                    errors++; $display("FAIL pass_wr_row_bank cycle=%0d got=%0d/%b required=%0d/%b",
                        c, weight_wr_row_o, weight_wr_bank_o, er, eb);
                end
            end
            checks++;
            if (compute_weights_rdy_o !== (c >= 34)) begin
                errors++; $display("FAIL pass_rdy cycle=%0d got=%b required=%b", c, compute_weights_rdy_o, (c >= 34));
            end
            @(negedge clk_i);
        end
        consume_pulse();
        checks++;
        if (done_o !== 1'b0 || compute_weights_rdy_o !== 1'b1) begin
            errors++; $display("FAIL pass_first_consume done=%b rdy=%b required 0/1", done_o, compute_weights_rdy_o);
        end
        consume_pulse();
        checks++;
        if (done_o !== 1'b1 || compute_weights_rdy_o !== 1'b0) begin
            errors++; $display("FAIL pass_done done=%b rdy=%b required 1/0", done_o, compute_weights_rdy_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0) begin
            errors++; $display("FAIL pass_done_width done=%b required 0", done_o);
        end
        $display("test_single_pass done");
    endtask

    // U=96 with no consume: stalls after two tiles, one consume refetches tile 2 at 0x140.
    task automatic test_stall_two_tiles();
        int reads;
        start_pass(8'd96, 12'h100);
        reads = 0;
        for (int c = 1; c <= 70; c++) begin
            if (weight_rd_en_o === 1'b1) reads++;
            @(negedge clk_i);
        end
        checks++;
        if (reads != 64) begin
            errors++; $display("FAIL stall_read_count got=%0d required=64", reads);
        end
        checks++;
        if (weight_rd_en_o !== 1'b0 || compute_weights_rdy_o !== 1'b1 || dut.full_cnt_reg !== 2'd2 || dut.state_reg !== WL_HOLD) begin
            errors++; $display("FAIL stall_hold rd_en=%b rdy=%b full_cnt=%0d state=%0d required 0/1/2/HOLD",
                weight_rd_en_o, compute_weights_rdy_o, dut.full_cnt_reg, dut.state_reg);
        end
        consume_pulse();
        checks++;
        if (weight_rd_en_o !== 1'b1 || weight_rd_addr_o !== 12'h140) begin
            errors++; $display("FAIL stall_refetch rd_en=%b addr=%h required 1/140", weight_rd_en_o, weight_rd_addr_o);
        end
        reads = 0;
        for (int c = 0; c < 40; c++) begin
            if (weight_rd_en_o === 1'b1) reads++;
            @(negedge clk_i);
        end
        checks++;
        if (reads != 32) begin
            errors++; $display("FAIL stall_third_tile_reads got=%0d required=32", reads);
        end
        consume_pulse();
        consume_pulse();
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL stall_done got=%b required=1", done_o);
        end
        @(negedge clk_i);
        $display("test_stall_two_tiles done");
    endtask

    // Consume lands on the completion write of tile 1: full_cnt stays 1.
    task automatic test_consume_on_completion();
        start_pass(8'd96, 12'h100);
        for (int c = 1; c < 65; c++) @(negedge clk_i);
        checks++;
        if (weight_wr_en_o !== 1'b1 || weight_wr_row_o !== 5'd31 || weight_wr_bank_o !== 1'b1 || dut.full_cnt_reg !== 2'd1) begin
            errors++; $display("FAIL coincide_setup wr_en=%b row=%0d bank=%b full_cnt=%0d required 1/31/1/1",
                weight_wr_en_o, weight_wr_row_o, weight_wr_bank_o, dut.full_cnt_reg);
        end
        consume_pulse();
        checks++;
        if (dut.full_cnt_reg !== 2'd1 || compute_weights_rdy_o !== 1'b1) begin
            errors++; $display("FAIL coincide_full_cnt full_cnt=%0d rdy=%b required 1/1", dut.full_cnt_reg, compute_weights_rdy_o);
        end
        checks++;
        if (weight_rd_en_o !== 1'b1 || weight_rd_addr_o !== 12'h140) begin
            errors++; $display("FAIL coincide_refetch rd_en=%b addr=%h required 1/140", weight_rd_en_o, weight_rd_addr_o);
        end
        repeat (40) @(negedge clk_i);
        consume_pulse();
        consume_pulse();
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL coincide_done got=%b required=1", done_o);
        end
        @(negedge clk_i);
        $display("test_consume_on_completion done");
    endtask

    // U=16 yields zero tiles; a stray consume during a fetch with rdy low is ignored.
    task automatic test_zero_tiles_and_idle_consume();
        start_pass(8'd16, 12'h000);
        checks++;
        if (done_o !== 1'b1 || weight_rd_en_o !== 1'b0) begin
            errors++; $display("FAIL zero_tiles_done done=%b rd_en=%b required 1/0", done_o, weight_rd_en_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || dut.state_reg !== WL_IDLE || weight_rd_en_o !== 1'b0) begin
            errors++; $display("FAIL zero_tiles_idle done=%b state=%0d rd_en=%b required 0/IDLE/0", done_o, dut.state_reg, weight_rd_en_o);
        end
        start_pass(8'd32, 12'h200);
        repeat (4) @(negedge clk_i);
        consume_pulse();
        checks++;
        if (dut.consumed_left_reg !== 8'd1 || dut.full_cnt_reg !== 2'd0 || weight_rd_en_o !== 1'b1 || weight_rd_addr_o !== 12'h205) begin
            errors++; $display("FAIL stray_consume consumed_left=%0d full_cnt=%0d rd_en=%b addr=%h required 1/0/1/205",
                dut.consumed_left_reg, dut.full_cnt_reg, weight_rd_en_o, weight_rd_addr_o);
        end
        repeat (27) @(negedge clk_i);
        checks++;
        if (compute_weights_rdy_o !== 1'b0) begin
            errors++; $display("FAIL one_tile_rdy_early cycle=33 got=%b required=0", compute_weights_rdy_o);
        end
        @(negedge clk_i);
        checks++;
        if (compute_weights_rdy_o !== 1'b1 || weight_rd_en_o !== 1'b0) begin
            errors++; $display("FAIL one_tile_rdy cycle=34 rdy=%b rd_en=%b required 1/0", compute_weights_rdy_o, weight_rd_en_o);
        end
`ifdef WEIGHT_LOAD_PERF_EN
        checks++;
        if (starve_cycles_o !== 32'd33) begin
            errors++; $display("FAIL starve_cycles got=%0d required=33", starve_cycles_o);
        end
`endif
        consume_pulse();
        checks++;
        if (done_o !== 1'b1 || dut.state_reg !== WL_IDLE) begin
            errors++; $display("FAIL one_tile_done done=%b state=%0d required 1/IDLE", done_o, dut.state_reg);
        end
        @(negedge clk_i);
        $display("test_zero_tiles_and_idle_consume done");
    endtask

    // Reset at row 10 clears outputs at once; the next start begins at row 0 of tile 0.
    task automatic test_reset_mid_tile();
        start_pass(8'd64, 12'h300);
        repeat (10) @(negedge clk_i);
        checks++;
        if (weight_rd_addr_o !== 12'h30A) begin
            errors++; $display("FAIL midtile_setup addr=%h required=30a", weight_rd_addr_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({weight_rd_en_o, weight_rd_addr_o, weight_wr_en_o, weight_wr_bank_o, weight_wr_row_o,
             compute_weights_rdy_o, done_o} !== '0) begin
            errors++; $display("FAIL midtile_reset rd_en=%b addr=%h wr_en=%b bank=%b row=%0d rdy=%b done=%b required all 0",
                weight_rd_en_o, weight_rd_addr_o, weight_wr_en_o, weight_wr_bank_o, weight_wr_row_o,
                compute_weights_rdy_o, done_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        start_pass(8'd32, 12'h300);
        checks++;
        if (weight_rd_en_o !== 1'b1 || weight_rd_addr_o !== 12'h300) begin
            errors++; $display("FAIL midtile_restart rd_en=%b addr=%h required 1/300", weight_rd_en_o, weight_rd_addr_o);
        end
        @(negedge clk_i);
        checks++;
        if (weight_wr_en_o !== 1'b1 || weight_wr_row_o !== 5'd0 || weight_wr_bank_o !== 1'b0) begin
            errors++; $display("FAIL midtile_first_write wr_en=%b row=%0d bank=%b required 1/0/0",
                weight_wr_en_o, weight_wr_row_o, weight_wr_bank_o);
        end
        repeat (32) @(negedge clk_i);
        consume_pulse();
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL midtile_done got=%b required=1", done_o);
        end
        @(negedge clk_i);
        $display("test_reset_mid_tile done");
    endtask

    initial begin
        rst_i              = 1'b1;
        start_i            = 1'b0;
        U_dim_i            = 8'd0;
        base_addr_i        = '0;
        next_weight_tile_i = 1'b0;
        weight_rd_data_i   = '0;
        test_reset();
        test_data_path();
        test_single_pass();
        test_stall_two_tiles();
        test_consume_on_completion();
        test_zero_tiles_and_idle_consume();
        test_reset_mid_tile();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_load_control_unit.md
# weight_load_control_unit

Producer side of the weight double-buffer handshake in the TPU datapath. It fetches MUL_SIZE-row weight tiles from the weight memory and writes them into the inactive bank of the systolic array's weight registers. It raises `compute_weights_rdy_o` while at least one full bank is waiting. It advances to the next tile when the compute controller pulses `next_weight_tile_i`. It sits between the weight memory and the MAC array, facing the compute control unit.

## Interface
Parameters:
- `MUL_SIZE`, 32: array dimension; rows per tile (from `tpu_package`).
- `DATA_W`, 8: weight element width.
- `ADDR_W`, 12: weight memory address width.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. One clock; reset is asynchronous and active-high.
- `start_i` input 1: pulse that begins a weight pass; ignored unless IDLE.
- `U_dim_i` input 8: weight matrix columns; tiles = `U_dim_i >> $clog2(MUL_SIZE)`.
- `base_addr_i` input ADDR_W: first row address; captured at `start_i`.
- `next_weight_tile_i` input 1: consume pulse from the compute controller; frees one full bank.
- `weight_rd_en_o` output 1: memory read strobe.
- `weight_rd_addr_o` output ADDR_W: memory row address.
- `weight_rd_data_i` input MUL_SIZE*DATA_W: memory row data, valid 1 cycle after `weight_rd_en_o`.
- `weight_wr_en_o` output 1: array weight-row write strobe.
- `weight_wr_bank_o` output 1: target bank.
- `weight_wr_row_o` output $clog2(MUL_SIZE): target row.
- `weight_wr_data_o` output MUL_SIZE*DATA_W: equals `weight_rd_data_i`, combinational.
- `compute_weights_rdy_o` output 1: at least one full, unconsumed bank.
- `done_o` output 1: one-cycle pulse when the last tile is consumed.

## Operation
- States:
  - IDLE
  - FETCH: issue one read per cycle.
  - HOLD: both banks full, or all tiles fetched.
- IDLE -> FETCH on `start_i` with tiles > 0.
  - The block latches the tile count and the base address.
  - `tiles_left` = tile count and `consumed_left` = tile count.
  - `wr_bank` is set to 0.
- `start_i` with tiles == 0: `done_o` pulses next cycle and the block stays IDLE.
- FETCH: `weight_rd_en_o`=1 each cycle.
  - Address = base + tile_idx*MUL_SIZE + row.
  - `row` counts 0..MUL_SIZE-1.
  - After row MUL_SIZE-1 is issued, the block decrements `tiles_left`.
  - It stays in FETCH if `full_cnt` after the pending fill is < 2 and `tiles_left` > 0; otherwise it moves to HOLD.
- Write pipeline: one register stage. `weight_wr_en_o`, `weight_wr_row_o` and `weight_wr_bank_o` are the read-side values delayed by 1 cycle.
- Bank completion: on the write of row MUL_SIZE-1, `full_cnt` increments and `wr_bank` toggles.
- `full_cnt` range is 0..2. `compute_weights_rdy_o` = (`full_cnt` != 0), registered.
- `next_weight_tile_i` with `full_cnt` > 0:
  - `full_cnt` decrements and `consumed_left` decrements.
  - If `consumed_left` reaches 0, `done_o` pulses and the block goes to IDLE.
- `next_weight_tile_i` with `full_cnt` == 0: ignored.
- Completion and consume on the same cycle: `full_cnt` is unchanged.
- HOLD -> FETCH when `full_cnt` < 2 and `tiles_left` > 0.
- Reset mid-operation clears all state. No partial tile survives.

## Timing
Reset values:
- All outputs 0, state IDLE.
- `full_cnt` 0, `wr_bank` 0, counters 0.

Cycle-level behaviour:
- Start latency: `start_i` at cycle 0 gives the first `weight_rd_en_o` at cycle 1 and the first `weight_wr_en_o` at cycle 2.
- One tile: MUL_SIZE consecutive read cycles with no bubbles inside a tile. `compute_weights_rdy_o` rises 1 cycle after the last write, at cycle MUL_SIZE+2.
- Back-to-back tiles: no idle cycle between them while `full_cnt` permits.
- Consume-to-refetch: `next_weight_tile_i` in HOLD at cycle t gives `weight_rd_en_o` at t+1.
- `done_o` is registered: 1 cycle after the final consume.

## Configuration
- `WEIGHT_LOAD_PERF_EN`, defined: adds output `starve_cycles_o` (32 bits, reset 0, saturating).
  - Counts cycles where state != IDLE and `compute_weights_rdy_o`==0.
  - Clears on `start_i`.
- Undefined: the port and counter are absent.

## Structure
- `tpu_package` holds:
  - `MUL_SIZE`
  - `DATA_W`
  - `WEIGHT_ADDR_W`
  - the state enum typedef `weight_load_state_t`
- Sub-module `weight_tile_addr_gen`: row/tile counters and address arithmetic, with `next` and `last_row` outputs.

## Test plan
- `U_dim_i`=64, base 0x100, start:
  - reads 0x100..0x13F with no gaps;
  - `compute_weights_rdy_o` high at cycle 34;
  - write banks 0 then 1.
- `U_dim_i`=96 with no consume:
  - the block stops after 2 tiles;
  - HOLD with `full_cnt`=2;
  - one `next_weight_tile_i` gives a read at 0x140 on the next cycle.
- Consume pulse on the exact cycle of the bank-completion write: `full_cnt` unchanged and `rdy` stays high.
- `U_dim_i`=16: `done_o` pulses 1 cycle after start with no reads. `next_weight_tile_i` with `rdy` low changes no state.
- Assert `rst_i` mid-tile (row 10): all outputs 0 immediately. A new start refetches from row 0 of tile 0.
- With `WEIGHT_LOAD_PERF_EN`: a single tile gives `starve_cycles_o`=33 at `rdy` rise.
